// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types (word, RAM handshake state)
// and the memory arbiter's FSM state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, DONE} arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between instruction and data ports.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-first priority.
module memory_arbiter
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      ramerr
);

    arb_state_t state_q, state_d;
    logic       d_req;
    logic       pick_i;

    assign d_req = dREN | dWEN;
    assign iload = ramload;
    assign dload = ramload;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    // Tracks which port completed last; aborts and errors leave it untouched.
    always_comb begin
        last_d_d = last_d_q;
        if (state_q == DGRANT && d_req && ramstate == ACCESS)
            last_d_d = 1'b1;
        else if (state_q == IGRANT && iREN && ramstate == ACCESS)
            last_d_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) last_d_q <= 1'b0;
        else       last_d_q <= last_d_d;

    assign pick_i = last_d_q;
`else
    assign pick_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (d_req && iREN) ? (pick_i ? IGRANT : DGRANT) :
                               d_req ? DGRANT : iREN ? IGRANT : IDLE;
            IGRANT:  state_d = !iREN ? IDLE : ramstate == ACCESS ? DONE :
                               ramstate == ERROR ? IDLE : IGRANT;
            DGRANT:  state_d = !d_req ? IDLE : ramstate == ACCESS ? DONE :
                               ramstate == ERROR ? IDLE : DGRANT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ramerr   = 1'b0;
        iwait    = iREN;
        dwait    = d_req;
        case (state_q)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                ramerr  = iREN && ramstate == ERROR;
                iwait   = iREN && ramstate != ACCESS;
            end
            DGRANT: begin
                // A simultaneous read+write request is served as a write.
                ramREN   = dREN & ~dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                ramerr   = d_req && ramstate == ERROR;
                dwait    = d_req && ramstate != ACCESS;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter with a latency/error RAM model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST = 1'b0;
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN, ramerr;
    ramstate_t ramstate;

    memory_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
    );

    always #5 CLK = ~CLK;

    // RAM model: two BUSY cycles then ACCESS; unwritten words read as 0x3C00FFC1 + addr.
    int          cnt = 0;
    logic        force_err = 1'b0;
    word_t       mem [0:255];
    logic [255:0] wr_mask = '0;
    wire         ram_en = ramREN | ramWEN;

    assign ramstate = !ram_en ? FREE : cnt == 2 ? (force_err ? ERROR : ACCESS) : BUSY;
    assign ramload  = wr_mask[ramaddr[9:2]] ? mem[ramaddr[9:2]] : 32'h3C00FFC1 + ramaddr;

    always @(posedge CLK) begin
        cnt <= (ram_en && ramstate == BUSY) ? cnt + 1 : 0;
        if (ramWEN && ramstate == ACCESS) begin
            mem[ramaddr[9:2]]     <= ramstore;
            wr_mask[ramaddr[9:2]] <= 1'b1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct { logic wr; word_t addr; word_t data; } txn_t;
    txn_t  iq[$], dq[$];
    byte   gl[$];
    word_t shadow[word_t];
    txn_t  mt;

    function automatic word_t exp_rd(word_t a);
        return shadow.exists(a) ? shadow[a] : 32'h3C00FFC1 + a;
    endfunction

    always @(negedge CLK) if (nRST) begin
        if (iREN && !iwait) begin
            gl.push_back("I");
            if (iq.size() == 0) check("i_unexpected", 1, 0);
            else begin
                mt = iq.pop_front();
                check("i_ramaddr", ramaddr, mt.addr);
                check("i_ramREN", {31'd0, ramREN}, 1);
                check("iload", iload, mt.data);
            end
        end
        if ((dREN || dWEN) && !dwait) begin
            gl.push_back("D");
            if (dq.size() == 0) check("d_unexpected", 1, 0);
            else begin
                mt = dq.pop_front();
                check("d_ramaddr", ramaddr, mt.addr);
                check("d_ramWEN", {31'd0, ramWEN}, {31'd0, mt.wr});
                check("d_ramREN", {31'd0, ramREN}, {31'd0, !mt.wr});
                check(mt.wr ? "ramstore" : "dload", mt.wr ? ramstore : dload, mt.data);
            end
        end
    end

    // Returns just after the clock edge that ends the completing cycle.
    task automatic wait_done(logic is_d);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (is_d ? !dwait : !iwait) begin
                @(posedge CLK); #1;
                return;
            end
        end
        check(is_d ? "d_timeout" : "i_timeout", 1, 0);
    endtask

    task automatic i_txn(word_t a);
        iaddr = a;
        iREN  = 1'b1;
        iq.push_back('{wr: 1'b0, addr: a, data: exp_rd(a)});
        wait_done(1'b0);
        iREN = 1'b0;
    endtask

    task automatic d_txn(word_t a, word_t data, logic wr, logic rd);
        daddr  = a;
        dstore = data;
        dWEN   = wr;
        dREN   = rd;
        dq.push_back('{wr: wr, addr: a, data: wr ? data : exp_rd(a)});
        if (wr) shadow[a] = data;
        wait_done(1'b1);
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iREN = 1'b1;
        #12;
        check("rst_ramREN", {31'd0, ramREN}, 0);
        check("rst_ramWEN", {31'd0, ramWEN}, 0);
        check("rst_ramerr", {31'd0, ramerr}, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_iwait", {31'd0, iwait}, 1);
        check("rst_dwait", {31'd0, dwait}, 0);
        iREN = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;

        // Single instruction read with registered grant and two BUSY cycles.
        @(posedge CLK); #1;
        iaddr = 32'h40;
        iREN  = 1'b1;
        iq.push_back('{wr: 1'b0, addr: 32'h40, data: 32'h3C010001});
        @(negedge CLK);
        check("t1_idle_ramREN", {31'd0, ramREN}, 0);
        check("t1_idle_iwait", {31'd0, iwait}, 1);
        @(negedge CLK);
        check("t1_grant_ramREN", {31'd0, ramREN}, 1);
        check("t1_ramaddr", ramaddr, 32'h40);
        check("t1_busy_iwait", {31'd0, iwait}, 1);
        @(negedge CLK);
        check("t1_busy2_iwait", {31'd0, iwait}, 1);
        @(negedge CLK);
        check("t1_access_iwait", {31'd0, iwait}, 0);
        check("t1_iload", iload, 32'h3C010001);
        @(posedge CLK); #1 iREN = 1'b0;
        @(negedge CLK);
        check("t1_done_ramREN", {31'd0, ramREN}, 0);

        // Simultaneous requests: data wins from reset/last=instruction in both modes.
        @(posedge CLK); #1;
        gl.delete();
        fork
            d_txn(32'h80, '0, 1'b0, 1'b1);
            i_txn(32'h44);
        join
        check("t2_n", gl.size(), 2);
        check("t2_g0", {24'd0, gl[0]}, "D");
        check("t2_g1", {24'd0, gl[1]}, "I");

        // Four back-to-back contended transactions.
        @(posedge CLK); #1;
        gl.delete();
        fork
            begin d_txn(32'h84, '0, 1'b0, 1'b1); d_txn(32'h88, '0, 1'b0, 1'b1); end
            begin i_txn(32'h54); i_txn(32'h58); end
        join
        check("t3_n", gl.size(), 4);
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_g0", {24'd0, gl[0]}, "D");
        check("t3_g1", {24'd0, gl[1]}, "I");
        check("t3_g2", {24'd0, gl[2]}, "D");
        check("t3_g3", {24'd0, gl[3]}, "I");
`else
        check("t3_g0", {24'd0, gl[0]}, "D");
        check("t3_g1", {24'd0, gl[1]}, "D");
        check("t3_g2", {24'd0, gl[2]}, "I");
        check("t3_g3", {24'd0, gl[3]}, "I");
`endif

        // Write, bubble, read-back; then a dREN+dWEN request served as a write.
        @(posedge CLK); #1;
        d_txn(32'h100, 32'hDEADBEEF, 1'b1, 1'b0);
        daddr = 32'h100;
        dREN  = 1'b1;
        dq.push_back('{wr: 1'b0, addr: 32'h100, data: exp_rd(32'h100)});
        @(negedge CLK);
        check("t4_bubble_ramREN", {31'd0, ramREN}, 0);
        check("t4_bubble_ramWEN", {31'd0, ramWEN}, 0);
        wait_done(1'b1);
        dREN = 1'b0;
        d_txn(32'h104, 32'h12345678, 1'b1, 1'b1);
        @(posedge CLK); #1;
        d_txn(32'h104, '0, 1'b0, 1'b1);

        // RAM error during instruction grant, then retry.
        @(posedge CLK); #1;
        force_err = 1'b1;
        iaddr = 32'h48;
        iREN  = 1'b1;
        iq.push_back('{wr: 1'b0, addr: 32'h48, data: exp_rd(32'h48)});
        for (int k = 0; k < 20 && !ramerr; k++) @(negedge CLK);
        check("t5_ramerr", {31'd0, ramerr}, 1);
        check("t5_iwait", {31'd0, iwait}, 1);
        @(posedge CLK); #1 force_err = 1'b0;
        @(negedge CLK);
        check("t5_ramerr_pulse", {31'd0, ramerr}, 0);
        check("t5_idle_ramREN", {31'd0, ramREN}, 0);
        wait_done(1'b0);
        iREN = 1'b0;

        // Data request dropped mid-grant.
        @(posedge CLK); #1;
        daddr = 32'h200;
        dREN  = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("t6_grant_ramREN", {31'd0, ramREN}, 1);
        @(posedge CLK); #1 dREN = 1'b0;
        @(negedge CLK);
        check("t6_drop_ramREN", {31'd0, ramREN}, 0);
        check("t6_drop_dwait", {31'd0, dwait}, 0);
        @(negedge CLK);
        check("t6_abort_ramREN", {31'd0, ramREN}, 0);
        @(posedge CLK); #1;
        i_txn(32'h4C);

        // Asynchronous reset in the middle of a data write grant.
        @(posedge CLK); #1;
        daddr  = 32'h300;
        dstore = 32'h1;
        dWEN   = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("t7_grant_ramWEN", {31'd0, ramWEN}, 1);
        #1 nRST = 1'b0;
        #1;
        check("t7_rst_ramWEN", {31'd0, ramWEN}, 0);
        check("t7_rst_ramREN", {31'd0, ramREN}, 0);
        check("t7_rst_ramaddr", ramaddr, 0);
        dWEN = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        @(posedge CLK); #1;
        iaddr = 32'h50;
        iREN  = 1'b1;
        iq.push_back('{wr: 1'b0, addr: 32'h50, data: exp_rd(32'h50)});
        @(negedge CLK);
        check("t7_idle_ramREN", {31'd0, ramREN}, 0);
        check("t7_idle_iwait", {31'd0, iwait}, 1);
        wait_done(1'b0);
        iREN = 1'b0;

        repeat (3) @(posedge CLK);
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have port: CLK  in  1  system clock, rising-edge.
REQ-002 SHALL have port: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: iREN  in  1  instruction read request; iaddr  in  32  instruction address.
REQ-004 SHALL have ports: iload  out  32  instruction data; iwait  out  1  instruction not ready.
REQ-005 SHALL have ports: dREN  in  1  data read request; dWEN  in  1  data write request.
REQ-006 SHALL have ports: daddr  in  32  data address; dstore  in  32  write data.
REQ-007 SHALL have ports: dload  out  32  read data; dwait  out  1  data not ready.
REQ-008 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32  (all to single-port RAM).
REQ-009 SHALL have ports: ramload  in  32  RAM read data; ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-010 SHALL have port: ramerr  out  1  one-cycle pulse on RAM ERROR.

Function
REQ-011 SHALL implement FSM states IDLE, IGRANT, DGRANT, DONE (arb_state_t).
- IDLE: RAM enables low.
- IDLE with dREN|dWEN -> DGRANT; otherwise with iREN -> IGRANT (priority per REQ-022/023).
REQ-012 SHALL register the grant: a request seen in IDLE at cycle N drives RAM from cycle N+1.
REQ-013 SHALL, in DGRANT, drive ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore combinationally.
REQ-014 SHALL, in IGRANT, drive ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-015 SHALL, if dREN and dWEN are both high, treat the request as a write (ramREN=0).
REQ-016 SHALL, when ramstate==ACCESS in a grant state, deassert the granted port's wait in that same cycle, pass ramload to iload/dload, and go to DONE.
REQ-017 SHALL, in DONE, hold RAM enables low for one bubble cycle and then return to IDLE.
REQ-018 SHALL hold each wait high while its request is high and it is not completing per REQ-016; wait is low when its request is low.
REQ-019 SHALL, if the granted port drops its request before ACCESS, abort to IDLE next cycle with RAM enables low that cycle.
REQ-020 SHALL, on ramstate==ERROR in a grant state, pulse ramerr for one cycle, keep the port's wait high, and go to IDLE (requester retries).
REQ-021 SHALL drive iload=ramload and dload=ramload at all times; they are valid only when the corresponding wait is low.

Configuration
REQ-022 SHALL, with ARB_ROUND_ROBIN_EN defined, use a 1-bit last-served flip-flop.
- With both ports requesting in IDLE, grant the port not served last.
- Update the flip-flop only on ACCESS completion.
REQ-023 SHALL, without ARB_ROUND_ROBIN_EN, give data fixed priority over instruction.

Reset
REQ-024 SHALL, on nRST low (asynchronous, including mid-grant), force state IDLE, ramREN=0, ramWEN=0, ramerr=0, and last-served=instruction.
REQ-025 SHALL, out of reset, drive ramaddr=0, ramstore=0, iwait=iREN, dwait=(dREN|dWEN).

Structure
REQ-026 SHALL take ramstate_t and word_t from cpu_types_pkg.
REQ-027 SHALL add arb_state_t to cpu_types_pkg.
REQ-028 SHALL be a single module with no sub-module; next-state logic and output decode in separate combinational blocks.

Verification
REQ-029 Single instruction read: iREN=1, iaddr=0x40, ACCESS after 2 BUSY cycles, ramload=0x3C010001 -> ramREN high from cycle 1; iwait low exactly at the ACCESS cycle; iload=0x3C010001.
REQ-030 Simultaneous requests, macro off: iREN=1, dREN=1, daddr=0x80 -> DGRANT first, ramaddr=0x80; after DONE, IGRANT with ramaddr=iaddr.
REQ-031 Simultaneous requests, macro on, 4 back-to-back transactions -> grants alternate D,I,D,I.
REQ-032 Write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF; dwait low on ACCESS; one idle bubble follows.
REQ-033 Errors and aborts:
- ERROR during IGRANT -> ramerr pulses once, iwait stays high, re-grant follows.
- dREN dropped mid-DGRANT -> enables low next cycle.
REQ-034 nRST asserted mid-DGRANT -> ramWEN/ramREN low immediately (asynchronous); state IDLE after release.
